// File: rtl/snoop_bus_controller.sv
// Shared-bus responder for MESI snooping: round-robin arbitration, snoop broadcast,
// response collection, and fill from the flushing owner or backing memory.
module snoop_bus_controller #(
  parameter int N_CACHES    = 2,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CACHES-1:0]          req_rd,
  input  logic [N_CACHES-1:0]          req_rdx,
  input  logic [N_CACHES*ADDR_W-1:0]   req_addr,
  input  logic [N_CACHES-1:0]          snoop_hit,
  input  logic [N_CACHES-1:0]          flush_in,
  input  logic [N_CACHES*DATA_W-1:0]   flush_data_in,
  output logic [N_CACHES-1:0]          grant,
  output logic [N_CACHES-1:0]          bus_rd_seen,
  output logic [N_CACHES-1:0]          bus_rdx_seen,
  output logic [ADDR_W-1:0]            snoop_addr,
  output logic [N_CACHES-1:0]          data_valid,
  output logic [DATA_W-1:0]            data_out,
  output logic                         shared_out,
  output logic                         bus_busy
);

  localparam int IDX_W = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, MEM_WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wait_cnt;
  logic               shared_reg;

  // Backing store starts zeroed and is deliberately untouched by reset.
  logic [DATA_W-1:0]  mem [1<<ADDR_W] = '{default: '0};

  logic [N_CACHES-1:0] req_any;
  logic [N_CACHES-1:0] flush_eff;
  logic                req_found;
  logic [IDX_W-1:0]    req_sel;
  logic                flush_found;
  logic [IDX_W-1:0]    flush_sel;
  logic [DATA_W-1:0]   flush_word;
  logic                shared_now;
  logic                mem_we;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    req_any   = req_rd | req_rdx;
    req_found = 1'b0;
    req_sel   = '0;
    for (int unsigned k = 0; k < N_CACHES; k++) begin
      idx = (32'(rr_ptr) + k) % N_CACHES;
      if (!req_found && req_any[IDX_W'(idx)]) begin
        req_found = 1'b1;
        req_sel   = IDX_W'(idx);
      end
    end

    // The requester's own snoop responses are masked out via grant.
    flush_eff   = flush_in & ~grant;
    shared_now  = |(snoop_hit & ~grant);
    flush_found = 1'b0;
    flush_sel   = '0;
    for (int unsigned i = 0; i < N_CACHES; i++) begin
      if (!flush_found && flush_eff[IDX_W'(i)]) begin
        flush_found = 1'b1;
        flush_sel   = IDX_W'(i);
      end
    end
    flush_word = flush_data_in[flush_sel*DATA_W +: DATA_W];
    mem_we     = !reset && (state == COLLECT) && flush_found;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[snoop_addr] <= flush_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      shared_reg   <= 1'b0;
      grant        <= '0;
      bus_rd_seen  <= '0;
      bus_rdx_seen <= '0;
      snoop_addr   <= '0;
      data_valid   <= '0;
      data_out     <= '0;
      shared_out   <= 1'b0;
      bus_busy     <= 1'b0;
    end else begin
      bus_rd_seen  <= '0;
      bus_rdx_seen <= '0;
      data_valid   <= '0;
      data_out     <= '0;
      shared_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_found) begin
            grant      <= N_CACHES'(1) << req_sel;
            snoop_addr <= req_addr[req_sel*ADDR_W +: ADDR_W];
            if (req_rdx[req_sel]) bus_rdx_seen <= ~(N_CACHES'(1) << req_sel);
            else                  bus_rd_seen  <= ~(N_CACHES'(1) << req_sel);
            rr_ptr     <= (req_sel == IDX_W'(N_CACHES - 1)) ? '0 : req_sel + 1'b1;
            bus_busy   <= 1'b1;
            state      <= SNOOP;
          end
        end
        SNOOP: state <= COLLECT;
        COLLECT: begin
          shared_reg <= shared_now;
          if (flush_found) begin
            data_valid <= grant;
            data_out   <= flush_word;
            shared_out <= shared_now;
            state      <= RESP;
          end else begin
            wait_cnt <= CNT_W'(MEM_LATENCY);
            state    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            data_valid <= grant;
            data_out   <= mem[snoop_addr];
            shared_out <= shared_reg;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          grant      <= '0;
          snoop_addr <= '0;
          bus_busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Bench for snoop_bus_controller: directed protocol scenarios then randomized traffic,
// checked against a transaction-level reference model.
module tb_snoop_bus_controller;

  localparam int N   = 4;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_rd, req_rdx, snoop_hit, flush_in;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   flush_data_in;
  logic [N-1:0]      grant, bus_rd_seen, bus_rdx_seen, data_valid;
  logic [AW-1:0]     snoop_addr;
  logic [DW-1:0]     data_out;
  logic              shared_out, bus_busy;

  snoop_bus_controller #(
    .N_CACHES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_rdx(req_rdx), .req_addr(req_addr),
    .snoop_hit(snoop_hit), .flush_in(flush_in), .flush_data_in(flush_data_in),
    .grant(grant), .bus_rd_seen(bus_rd_seen), .bus_rdx_seen(bus_rdx_seen),
    .snoop_addr(snoop_addr), .data_valid(data_valid), .data_out(data_out),
    .shared_out(shared_out), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending requests per cache, rr pointer, sparse memory image.
  bit              pend [N];
  int              kind [N];   // 0 = BusRd, 1 = BusRdX, 2 = both lines raised
  logic [AW-1:0]   paddr [N];
  int unsigned     ptr_m;
  logic [DW-1:0]   mem_m [logic [AW-1:0]];
  logic [N-1:0]    col_hit, col_flush;
  logic [DW-1:0]   col_data [N];
  bit              auto_mode;

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    return mem_m.exists(a) ? mem_m[a] : '0;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] pool [4];
    pool = '{13'h00A5, 13'h1F00, 13'h0001, 13'h1FFF};
    if ($urandom_range(0, 4) == 4) return AW'($urandom);
    return pool[$urandom_range(0, 3)];
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_rd[i]  = pend[i] && kind[i] != 1;
      req_rdx[i] = pend[i] && kind[i] != 0;
      req_addr[i*AW +: AW] = paddr[i];
    end
  endtask

  task automatic set_req(input int i, input int k, input logic [AW-1:0] a);
    pend[i] = 1'b1; kind[i] = k; paddr[i] = a;
  endtask

  task automatic set_col(input logic [N-1:0] h, input logic [N-1:0] f, input logic [DW-1:0] d);
    col_hit = h; col_flush = f;
    for (int i = 0; i < N; i++) col_data[i] = d;
  endtask

  task automatic add_random_reqs(input bit min_one);
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, 2), pick_addr());
      any |= pend[i];
    end
    if (min_one && !any) set_req($urandom_range(0, N-1), $urandom_range(0, 2), pick_addr());
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_rd_seen"}, bus_rd_seen, 0);
    check({tag, "_rdx_seen"}, bus_rdx_seen, 0);
    check({tag, "_addr"}, snoop_addr, 0);
    check({tag, "_dv"}, data_valid, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_shared"}, shared_out, 0);
    check({tag, "_busy"}, bus_busy, 0);
  endtask

  // Entered at a negedge with the controller idle; returns at the next idle negedge.
  task automatic txn();
    int unsigned   w;
    bit            found;
    logic [N-1:0]  g1, ng, zero_n;
    logic [AW-1:0] a;
    int            fl, lat;
    logic [DW-1:0] ed;
    bit            es;
    apply_reqs();
    check("idle_busy", bus_busy, 0);
    check("idle_grant", grant, 0);
    found = 1'b0; w = 0;
    for (int k = 0; k < N; k++)
      if (!found && pend[(ptr_m + k) % N]) begin found = 1'b1; w = (ptr_m + k) % N; end
    if (!found) return;
    ptr_m  = (w + 1) % N;
    g1     = N'(1) << w;
    ng     = ~g1;
    zero_n = '0;
    a      = paddr[w];

    @(negedge clk);
    check("grant", grant, g1);
    check("snoop_addr", snoop_addr, a);
    check("busy", bus_busy, 1);
    check("rd_seen", bus_rd_seen, (kind[w] == 0) ? ng : zero_n);
    check("rdx_seen", bus_rdx_seen, (kind[w] != 0) ? ng : zero_n);
    check("snoop_dv", data_valid, 0);

    @(negedge clk);
    check("collect_seen", bus_rd_seen | bus_rdx_seen, 0);
    snoop_hit = col_hit;
    flush_in  = col_flush;
    for (int i = 0; i < N; i++) flush_data_in[i*DW +: DW] = col_data[i];
    fl = -1;
    for (int i = 0; i < N; i++) if (fl < 0 && i != int'(w) && col_flush[i]) fl = i;
    es = |(col_hit & ng);
    if (fl >= 0) begin
      ed = col_data[fl]; mem_m[a] = ed; lat = 1;
    end else begin
      ed = rd_mem(a); lat = 1 + LAT;
    end

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      snoop_hit = N'($urandom);
      flush_in  = N'($urandom);
      for (int i = 0; i < N; i++) flush_data_in[i*DW +: DW] = $urandom;
      if (c < lat) begin
        check("wait_dv", data_valid, 0);
        check("wait_grant", grant, g1);
      end
    end
    check("resp_dv", data_valid, g1);
    check("resp_data", data_out, ed);
    check("resp_shared", shared_out, es);
    check("resp_grant", grant, g1);

    pend[w] = 1'b0;
    if (auto_mode) add_random_reqs(1'b0);
    apply_reqs();
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0; ptr_m = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    apply_reqs();
    snoop_hit = '0; flush_in = '0;
  endtask

  initial begin
    reset = 1'b1; req_rd = '0; req_rdx = '0; req_addr = '0;
    snoop_hit = '0; flush_in = '0; flush_data_in = '0; auto_mode = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; kind[i] = 0; paddr[i] = '0; end
    repeat (2) @(negedge clk);
    check_quiet("reset");
    release_reset();
    @(negedge clk);

    set_req(0, 0, 13'h00A5); set_col('0, '0, '0); txn();                      // cold memory
    set_req(0, 0, 13'h00A5); set_col(4'b0010, 4'b0010, 32'h12345678); txn();  // owner flush
    set_req(1, 0, 13'h00A5); set_col('0, '0, '0); txn();                      // written back
    set_req(1, 1, 13'h1F00); txn();                                           // BusRdX, ptr -> 2
    set_req(1, 0, 13'h0001); set_req(3, 2, 13'h1F00); txn(); txn();           // 3 before 1
    set_req(0, 0, 13'h00A5); set_col(4'b0001, 4'b0001, 32'hBAD0BAD0); txn();  // own bits ignored

    // Reset during MEM_WAIT.
    set_req(0, 0, 13'h00A5); apply_reqs();
    @(negedge clk);
    @(negedge clk);
    snoop_hit = '0; flush_in = '0;
    @(negedge clk);
    check("memwait_busy", bus_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("rst_memwait");
    release_reset();
    @(negedge clk);
    check("rst_memwait_dv", data_valid, 0);
    check("rst_memwait_idle", bus_busy, 0);

    // Reset in COLLECT with a flush pending must not write memory.
    set_req(0, 0, 13'h00A5); apply_reqs();
    @(negedge clk);
    @(negedge clk);
    snoop_hit = 4'b0010; flush_in = 4'b0010; flush_data_in = {N{32'hDEADBEEF}};
    reset = 1'b1;
    @(negedge clk);
    check_quiet("rst_collect");
    release_reset();
    @(negedge clk);
    set_req(1, 0, 13'h00A5); set_col('0, '0, '0); txn();

    auto_mode = 1'b1;
    repeat (300) begin
      col_hit   = N'($urandom);
      col_flush = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) col_data[i] = $urandom;
      add_random_reqs(1'b1);
      txn();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
